// File: rtl/hwpe_mem_rr_arbiter.sv
// Round-robin arbiter sharing one HWPE memory port between N_MASTER requesters; in-order ID FIFO routes responses back.
// Grant and response routing are combinational (0 cycles); grants stall while MAX_OUTSTANDING IDs are in flight or out_gnt_i is low.

module hwpe_mem_rr_arbiter_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign count    = cnt;
  assign head_dat = mem[rd_ptr];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module hwpe_mem_rr_arbiter #(
  parameter int N_MASTER        = 4,
  parameter int ADDR_WIDTH      = 13,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_WIDTH        = $clog2(N_MASTER)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_MASTER-1:0]                  in_req_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0]       in_add_i,
  input  logic [N_MASTER-1:0]                  in_wen_i,
  input  logic [N_MASTER*DATA_WIDTH-1:0]       in_wdata_i,
  input  logic [N_MASTER*BE_WIDTH-1:0]         in_be_i,
  output logic [N_MASTER-1:0]                  in_gnt_o,
  output logic [N_MASTER-1:0]                  in_r_valid_o,
  output logic [DATA_WIDTH-1:0]                in_r_rdata_o,
  output logic                                 out_req_o,
  output logic [ADDR_WIDTH-1:0]                out_add_o,
  output logic                                 out_wen_o,
  output logic [DATA_WIDTH-1:0]                out_wdata_o,
  output logic [BE_WIDTH-1:0]                  out_be_o,
  input  logic                                 out_gnt_i,
  input  logic                                 out_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                out_r_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o
);
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] winner;
  logic [ID_WIDTH-1:0] cand;
  logic                winner_found;
  logic [ID_WIDTH-1:0] head_id;
  logic                fifo_empty;
  logic                fifo_full;
  logic                handshake;
  logic                pop;
  logic                err_q;

  // Search order starts at rr_ptr so the last winner has lowest priority next time.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    cand         = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      cand = ID_WIDTH'((int'(rr_ptr) + k) % N_MASTER);
      if (!winner_found && in_req_i[cand]) begin
        winner_found = 1'b1;
        winner       = cand;
      end
    end
  end

  assign out_req_o = !rst && !fifo_full && winner_found;
  assign handshake = out_req_o && out_gnt_i;
  // Full is judged on pre-pop occupancy, so a freed slot is reusable only next cycle.
  assign pop       = !rst && out_r_valid_i && !fifo_empty;

  always_comb begin
    out_add_o   = '0;
    out_wen_o   = 1'b0;
    out_wdata_o = '0;
    out_be_o    = '0;
    in_gnt_o    = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (out_req_o && winner == ID_WIDTH'(i)) begin
        out_add_o   = in_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        out_wen_o   = in_wen_i[i];
        out_wdata_o = in_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        out_be_o    = in_be_i[i*BE_WIDTH +: BE_WIDTH];
      end
      in_gnt_o[i] = handshake && (winner == ID_WIDTH'(i));
    end
  end

  always_comb begin
    in_r_valid_o = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      in_r_valid_o[i] = pop && (head_id == ID_WIDTH'(i));
    end
  end

  assign in_r_rdata_o = out_r_rdata_i;

  hwpe_mem_rr_arbiter_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_WIDTH)
  ) u_id_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (handshake),
    .push_dat (winner),
    .pop      (pop),
    .head_dat (head_id),
    .count    (outstanding_o),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      err_q  <= 1'b0;
    end else begin
      if (handshake) begin
        rr_ptr <= (winner == ID_WIDTH'(N_MASTER - 1)) ? '0 : winner + 1'b1;
      end
      if (out_r_valid_i && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
endmodule

// File: tb/tb_hwpe_mem_rr_arbiter.sv
// Directed bench for hwpe_mem_rr_arbiter: arbitration order, stalls, full limit, response routing, error and reset.
module tb_hwpe_mem_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int BW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_req;
  logic [N*AW-1:0] in_add;
  logic [N-1:0]    in_wen;
  logic [N*DW-1:0] in_wdata;
  logic [N*BW-1:0] in_be;
  logic [N-1:0]    in_gnt;
  logic [N-1:0]    in_r_valid;
  logic [DW-1:0]   in_r_rdata;
  logic            out_req;
  logic [AW-1:0]   out_add;
  logic            out_wen;
  logic [DW-1:0]   out_wdata;
  logic [BW-1:0]   out_be;
  logic            out_gnt;
  logic            out_r_valid;
  logic [DW-1:0]   out_r_rdata;
  logic [2:0]      outstanding;
  logic            err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hwpe_mem_rr_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .in_req_i      (in_req),
    .in_add_i      (in_add),
    .in_wen_i      (in_wen),
    .in_wdata_i    (in_wdata),
    .in_be_i       (in_be),
    .in_gnt_o      (in_gnt),
    .in_r_valid_o  (in_r_valid),
    .in_r_rdata_o  (in_r_rdata),
    .out_req_o     (out_req),
    .out_add_o     (out_add),
    .out_wen_o     (out_wen),
    .out_wdata_o   (out_wdata),
    .out_be_o      (out_be),
    .out_gnt_i     (out_gnt),
    .out_r_valid_i (out_r_valid),
    .out_r_rdata_i (out_r_rdata),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d);
    in_add[i*AW +: AW]   = a;
    in_wen[i]            = wr;
    in_wdata[i*DW +: DW] = d;
    in_be[i*BW +: BW]    = 4'hF;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_req = '0;
    out_gnt = 1'b0;
    out_r_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    in_req = 4'hF;
    in_add = '0;
    in_wen = '0;
    in_wdata = '0;
    in_be = '0;
    out_gnt = 1'b1;
    out_r_valid = 1'b0;
    out_r_rdata = '0;
    for (int i = 0; i < N; i++) set_master(i, AW'(13'h100 + i), 1'b0, 32'hA000_0000 + i);
    #2;
    check("rst_out_req", out_req, 1'b0);
    check("rst_gnt", in_gnt, 4'b0000);
    check("rst_outstanding", outstanding, 3'd0);
    check("rst_err", err, 1'b0);
    do_reset();

    // Single read from master 2
    set_master(2, 13'h010, 1'b0, 32'h0);
    in_req = 4'b0100;
    out_gnt = 1'b1;
    @(negedge clk);
    check("t1_gnt", in_gnt, 4'b0100);
    check("t1_add", out_add, 13'h010);
    check("t1_wen", out_wen, 1'b0);
    check("t1_outst0", outstanding, 3'd0);
    tick();
    in_req = '0;
    out_r_valid = 1'b1;
    out_r_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_rvalid", in_r_valid, 4'b0100);
    check("t1_rdata", in_r_rdata, 32'hDEADBEEF);
    check("t1_outst1", outstanding, 3'd1);
    check("t1_idle_req", out_req, 1'b0);
    check("t1_idle_add", out_add, 13'h000);
    tick();
    out_r_valid = 1'b0;
    @(negedge clk);
    check("t1_outst_end", outstanding, 3'd0);
    check("t1_rvalid_end", in_r_valid, 4'b0000);

    // All four requesting, one-cycle response latency
    do_reset();
    for (int i = 0; i < N; i++) set_master(i, AW'(13'h200 + i), i[0], 32'hB000_0000 + i);
    in_req = 4'hF;
    out_gnt = 1'b1;
    for (int k = 0; k < 8; k++) begin
      out_r_valid = (k > 0);
      out_r_rdata = 32'h1000 + k;
      @(negedge clk);
      check("t2_gnt", in_gnt, 4'b0001 << (k % 4));
      check("t2_add", out_add, 13'h200 + (k % 4));
      check("t2_wdata", out_wdata, 32'hB000_0000 + (k % 4));
      check("t2_rvalid", in_r_valid, (k == 0) ? 4'b0000 : (4'b0001 << ((k - 1) % 4)));
      tick();
    end
    in_req = '0;
    out_r_valid = 1'b1;
    @(negedge clk);
    check("t2_last_rvalid", in_r_valid, 4'b1000);
    tick();
    out_r_valid = 1'b0;
    @(negedge clk);
    check("t2_outst_end", outstanding, 3'd0);

    // Memory stalls with requests from 1 and 3 (rr_ptr is 0)
    in_req = 4'b1010;
    out_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_stall_gnt", in_gnt, 4'b0000);
      check("t3_stall_req", out_req, 1'b1);
      check("t3_stall_add", out_add, 13'h201);
      tick();
    end
    out_gnt = 1'b1;
    @(negedge clk);
    check("t3_first_gnt", in_gnt, 4'b0010);
    tick();
    @(negedge clk);
    check("t3_second_gnt", in_gnt, 4'b1000);
    tick();
    in_req = '0;
    out_r_valid = 1'b1;
    @(negedge clk);
    check("t3_outst", outstanding, 3'd2);
    check("t3_rv1", in_r_valid, 4'b0010);
    tick();
    @(negedge clk);
    check("t3_rv3", in_r_valid, 4'b1000);
    tick();
    out_r_valid = 1'b0;

    // Fill the ID FIFO (rr_ptr is 0)
    in_req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t4_fill_gnt", in_gnt, 4'b0001 << k);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t4_full_gnt", in_gnt, 4'b0000);
      check("t4_full_req", out_req, 1'b0);
      check("t4_full_outst", outstanding, 3'd4);
      tick();
    end
    out_r_valid = 1'b1;
    @(negedge clk);
    check("t4_pop_rvalid", in_r_valid, 4'b0001);
    check("t4_pop_gnt", in_gnt, 4'b0000);
    tick();
    out_r_valid = 1'b0;
    @(negedge clk);
    check("t4_regrant", in_gnt, 4'b0001);
    check("t4_outst3", outstanding, 3'd3);
    tick();
    in_req = '0;
    out_r_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t4_drain", in_r_valid, (k == 3) ? 4'b0001 : (4'b0010 << k));
      tick();
    end
    out_r_valid = 1'b0;

    // Stray response with empty FIFO
    @(negedge clk);
    check("t5_empty", outstanding, 3'd0);
    tick();
    out_r_valid = 1'b1;
    @(negedge clk);
    check("t5_no_rvalid", in_r_valid, 4'b0000);
    tick();
    out_r_valid = 1'b0;
    @(negedge clk);
    check("t5_err_set", err, 1'b1);
    check("t5_outst", outstanding, 3'd0);
    tick();
    tick();
    @(negedge clk);
    check("t5_err_sticky", err, 1'b1);

    // Three outstanding (rr_ptr is 1), then async reset
    tick();
    in_req = 4'hF;
    out_gnt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_gnt", in_gnt, 4'b0010 << k);
      tick();
    end
    @(negedge clk);
    check("t6_outst3", outstanding, 3'd3);
    #2;
    rst = 1'b1;
    out_r_valid = 1'b1;
    #1;
    check("t6_rst_outst", outstanding, 3'd0);
    check("t6_rst_req", out_req, 1'b0);
    check("t6_rst_gnt", in_gnt, 4'b0000);
    check("t6_rst_rvalid", in_r_valid, 4'b0000);
    check("t6_rst_err", err, 1'b0);
    tick();
    rst = 1'b0;
    in_req = '0;
    @(negedge clk);
    check("t6_late_rvalid", in_r_valid, 4'b0000);
    tick();
    out_r_valid = 1'b0;
    in_req = 4'hF;
    @(negedge clk);
    check("t6_late_err", err, 1'b1);
    check("t6_restart_gnt", in_gnt, 4'b0001);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hwpe_mem_rr_arbiter.md
# hwpe_mem_rr_arbiter

Round-robin arbiter sharing one HWPE-style memory master port between N_MASTER HWPE-style requesters, e.g. several AXI-slave memory bridges or accelerator streamers in front of a single TCDM bank group. It grants one request per cycle, tracks in-order responses in an ID FIFO and routes each `r_valid`/`r_rdata` back to the requester that issued it. Outstanding transactions are bounded by MAX_OUTSTANDING; the block stalls grants when that limit is reached.

## Interface
- N_MASTER, 4: number of requesters (≥2).
- ADDR_WIDTH, 13: word address width (matches ADDR_MEM_TOTAL_WIDTH of the memory side).
- DATA_WIDTH, 32: data width.
- BE_WIDTH, DATA_WIDTH/8: byte-enable width.
- MAX_OUTSTANDING, 4: ID FIFO depth; max granted-but-unanswered transactions.
- ID_WIDTH, $clog2(N_MASTER): internal requester index width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_req_i  in  N_MASTER  per-requester request.
- in_add_i  in  N_MASTER*ADDR_WIDTH  addresses, requester i at slice i.
- in_wen_i  in  N_MASTER  1 = write, 0 = read.
- in_wdata_i  in  N_MASTER*DATA_WIDTH  write data.
- in_be_i  in  N_MASTER*BE_WIDTH  byte enables.
- in_gnt_o  out  N_MASTER  one-hot (or zero) grant.
- in_r_valid_o  out  N_MASTER  one-hot (or zero) response valid.
- in_r_rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters.
- out_req_o  out  1  request to memory.
- out_add_o  out  ADDR_WIDTH  address of winner.
- out_wen_o  out  1  write enable of winner.
- out_wdata_o  out  DATA_WIDTH  write data of winner.
- out_be_o  out  BE_WIDTH  byte enable of winner.
- out_gnt_i  in  1  memory grant.
- out_r_valid_i  in  1  memory response valid (one per granted transaction, read or write, in order).
- out_r_rdata_i  in  DATA_WIDTH  memory read data.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current FIFO occupancy.
- err_o  out  1  sticky: response received with FIFO empty.

## Operation
- State: rr_ptr (ID_WIDTH), ID FIFO (MAX_OUTSTANDING entries × ID_WIDTH, wr/rd pointers wrapping modulo depth, occupancy count), err_o flop.
- Winner: first i with in_req_i[i]=1 searching rr_ptr, rr_ptr+1, … wrapping modulo N_MASTER. No winner if in_req_i==0.
- full = (occupancy == MAX_OUTSTANDING). When full: out_req_o=0, all grants 0.
- Otherwise out_req_o = |in_req_i; out_add/wen/wdata/be = winner's fields; when no request, payload outputs are 0.
- Handshake = out_req_o & out_gnt_i: in_gnt_o[winner]=1 (combinational from out_gnt_i); winner ID pushed; rr_ptr ← (winner+1) mod N_MASTER. No handshake → rr_ptr unchanged.
- Response: out_r_valid_i=1 with FIFO non-empty → pop head ID h; in_r_valid_o[h]=1 same cycle; in_r_rdata_o = out_r_rdata_i always (pass-through).
- Simultaneous push and pop: occupancy unchanged, both performed. Full state is evaluated before the pop, so a pop in a full cycle does not enable a grant in that same cycle.
- out_r_valid_i with FIFO empty: no in_r_valid_o, occupancy stays 0, err_o ← 1 until reset.
- Requesters hold request and payload until granted; the arbiter does not check this.

## Timing
- Grant path is combinational: in_req_i/out_gnt_i → in_gnt_o in the same cycle; response routing is combinational from FIFO head → in_r_valid_o in the same cycle.
- Memory response latency ≥1 cycle after the handshake; a response in the same cycle as its own grant is not supported.
- Reset (async assert): rr_ptr=0, FIFO empty, occupancy 0, err_o=0; while rst=1, out_req_o=0, in_gnt_o=0, in_r_valid_o=0. Reset mid-operation drops all outstanding IDs; late memory responses after reset set err_o.
- Throughput: one grant per cycle while not full; sustained N_MASTER-way fairness: each continuously requesting master is granted at least once every N_MASTER handshakes.

## Test plan
- Single requester 2 issues read add=0x010 with memory out_gnt_i=1, 1-cycle read latency, rdata=0xDEADBEEF -> in_gnt_o=0b0100 same cycle, next cycle in_r_valid_o=0b0100, in_r_rdata_o=0xDEADBEEF, outstanding_o 1→0.
- All 4 requesters request continuously, out_gnt_i=1 -> grant order 0,1,2,3,0,1… ; every grant's response returns to the matching index.
- out_gnt_i=0 for 3 cycles with requests from 1 and 3 -> no grants, rr_ptr unchanged; when out_gnt_i=1, master 1 granted first.
- Memory never responds, continuous requests -> exactly 4 grants, outstanding_o=4, out_req_o=0; one response pops ID of first grant, next cycle a new grant issues.
- out_r_valid_i pulse with FIFO empty -> in_r_valid_o=0, err_o=1 and stays 1 until rst.
- Assert rst with 3 outstanding -> outstanding_o=0, outputs zero immediately (asynchronously); after release, round-robin restarts from master 0.
